// File: rtl/shufflev_perm_gen_pkg.sv
// Shared types and helpers for the ShuffleV permutation generator.
// Optional feature macro used by this block: SHUFFLEV_PERM_FOLD_EN.
package shufflev_perm_gen_pkg;

    // Generator states: waiting for enable, building a permutation,
    // holding a finished permutation while the output slot is occupied.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHUFFLE = 2'd1,
        FULL    = 2'd2
    } shufflev_perm_state_e;

    // Width of the consecutive-reject counter; always at least one bit.
    function automatic int retry_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/shufflev_perm_gen_if.sv
// Random-draw input stream and permutation output handshake of the
// ShuffleV permutation generator, grouped as one bundle.
// master: the generator. slave: the rng/consumer side.
// Optional feature macro used by this block: SHUFFLEV_PERM_FOLD_EN.
interface shufflev_perm_gen_if #(
    parameter int NumSlots = 4,
    parameter int IdxW     = $clog2(NumSlots)
);

    logic [IdxW-1:0]          rng_number_i;
    logic                     rng_valid_i;
    logic [NumSlots*IdxW-1:0] perm_o;
    logic                     perm_valid_o;
    logic                     perm_ready_i;

    modport master (
        input  rng_number_i,
        input  rng_valid_i,
        input  perm_ready_i,
        output perm_o,
        output perm_valid_o
    );

    modport slave (
        output rng_number_i,
        output rng_valid_i,
        output perm_ready_i,
        input  perm_o,
        input  perm_valid_o
    );

endinterface

// File: rtl/shufflev_perm_draw.sv
// Decides what one random draw means for the current Fisher-Yates step:
// accept it as the swap partner, reject it, or (after too many rejects in
// a row) force a no-swap so the step always finishes in bounded time.
// Optional feature macro: SHUFFLEV_PERM_FOLD_EN -- an out-of-range draw is
// first folded down by (i+1) and accepted if it then lands in range.
module shufflev_perm_draw
    import shufflev_perm_gen_pkg::*;
#(
    parameter int NumSlots   = 4,
    parameter int RetryLimit = 3,
    parameter int IdxW       = $clog2(NumSlots),
    parameter int RetryW     = retry_width(RetryLimit)
) (
    input  logic [IdxW-1:0]   d_i,
    input  logic [IdxW-1:0]   i_i,
    input  logic [RetryW-1:0] retry_i,
    output logic              accept_o,
    output logic              forced_o,
    output logic [IdxW-1:0]   j_o
);

    localparam logic [IdxW-1:0]   IDX_ONE    = IdxW'(1);
    localparam logic [RetryW-1:0] RETRY_LAST = RetryW'(RetryLimit - 1);

    logic [IdxW-1:0] dEff;

    // Classify the draw; a forced step uses j=i, which makes the swap a no-op.
    always_comb begin
        dEff = d_i;
`ifdef SHUFFLEV_PERM_FOLD_EN
        if (d_i > i_i) begin
            dEff = d_i - (i_i + IDX_ONE);
        end
`endif
        accept_o = (dEff <= i_i);
        forced_o = !accept_o && (retry_i == RETRY_LAST);
        j_o      = accept_o ? dEff : i_i;
    end

endmodule

// File: rtl/shufflev_perm_gen.sv
// ShuffleV permutation generator. Consumes the shufflev_rng draw stream and
// builds uniform random permutations of slot indices 0..NumSlots-1 with
// Fisher-Yates, handing each one over a valid/ready handshake. The next
// permutation is built in work_q while perm_q waits to be taken.
// Optional feature macro: SHUFFLEV_PERM_FOLD_EN (draw folding, see
// shufflev_perm_draw).
module shufflev_perm_gen
    import shufflev_perm_gen_pkg::*;
#(
    parameter int NumSlots   = 4,
    parameter int RetryLimit = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    shufflev_perm_gen_if.master bus
);

    localparam int IDX_W   = $clog2(NumSlots);
    localparam int RETRY_W = retry_width(RetryLimit);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NumSlots - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

    shufflev_perm_state_e state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [NumSlots-1:0][IDX_W-1:0] work_q, work_d;
    logic [NumSlots-1:0][IDX_W-1:0] perm_q, perm_d;
    logic                 valid_q, valid_d;

    logic [NumSlots-1:0][IDX_W-1:0] workSwapped;
    logic                 drawAccept;
    logic                 drawForced;
    logic [IDX_W-1:0]     drawJ;
    logic                 stepDone;
    logic                 handshake;
    logic                 slotFree;

    shufflev_perm_draw #(
        .NumSlots   (NumSlots),
        .RetryLimit (RetryLimit),
        .IdxW       (IDX_W),
        .RetryW     (RETRY_W)
    ) u_draw (
        .d_i      (bus.rng_number_i),
        .i_i      (idx_q),
        .retry_i  (retry_q),
        .accept_o (drawAccept),
        .forced_o (drawForced),
        .j_o      (drawJ)
    );

    assign stepDone  = drawAccept || drawForced;
    assign handshake = valid_q && bus.perm_ready_i;
    assign slotFree  = !valid_q || bus.perm_ready_i;

    // Working array with slots i and j exchanged (unchanged when j == i).
    always_comb begin
        workSwapped        = work_q;
        workSwapped[idx_q] = work_q[drawJ];
        workSwapped[drawJ] = work_q[idx_q];
    end

    // Next-state logic for the shuffle FSM, step index, retry counter and handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        work_d  = work_q;
        perm_d  = perm_q;
        valid_d = valid_q;

        if (handshake) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = SHUFFLE;
                    idx_d   = LAST_IDX;
                    retry_d = '0;
                end
            end

            SHUFFLE: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (bus.rng_valid_i) begin
                    if (stepDone) begin
                        work_d  = workSwapped;
                        retry_d = '0;
                        if (idx_q == IDX_ONE) begin
                            idx_d = LAST_IDX;
                            if (slotFree) begin
                                perm_d  = workSwapped;
                                valid_d = 1'b1;
                            end else begin
                                state_d = FULL;
                            end
                        end else begin
                            idx_d = idx_q - IDX_ONE;
                        end
                    end else begin
                        retry_d = retry_q + RETRY_ONE;
                    end
                end
            end

            FULL: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (bus.perm_ready_i) begin
                    perm_d  = work_q;
                    valid_d = 1'b1;
                    state_d = SHUFFLE;
                    idx_d   = LAST_IDX;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset restores identity arrays and an empty output slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= LAST_IDX;
            retry_q <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < NumSlots; k++) begin
                work_q[k] <= IDX_W'(k);
                perm_q[k] <= IDX_W'(k);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            work_q  <= work_d;
            perm_q  <= perm_d;
            valid_q <= valid_d;
        end
    end

    assign bus.perm_o       = perm_q;
    assign bus.perm_valid_o = valid_q;

endmodule

// File: tb/tb_shufflev_perm_gen.sv
// Bench for shufflev_perm_gen (NumSlots=4, RetryLimit=3). A Fisher-Yates
// reference model runs alongside the DUT and is compared every cycle;
// hand-computed permutations pin the model at key points.
// Honours SHUFFLEV_PERM_FOLD_EN in the same way as the design.
module tb_shufflev_perm_gen;

    localparam int N  = 4;
    localparam int RL = 3;
    localparam int IW = 2;
    localparam int PW = N * IW;
`ifdef SHUFFLEV_PERM_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif
    localparam logic [PW-1:0] IDENT = 8'hE4;

    logic clk;
    logic rst;
    logic en;

    int nChecks = 0;
    int nFails  = 0;
    bit cmpOn   = 1'b0;

    shufflev_perm_gen_if #(.NumSlots(N)) bus ();

    shufflev_perm_gen #(
        .NumSlots   (N),
        .RetryLimit (RL)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain integer arrays and a mode flag.
    int  mWork[N];
    int  mPerm[N];
    bit  mValid;
    int  mMode;
    int  mI;
    int  mRetry;
    int  mD;
    int  mJ;
    int  mTmp;

    // Advance the model one clock from the inputs present at the edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mWork[k] = k;
                mPerm[k] = k;
            end
            mValid = 1'b0;
            mMode  = 0;
            mI     = N - 1;
            mRetry = 0;
        end else begin
            if (mValid && bus.perm_ready_i) mValid = 1'b0;
            if (mMode == 0) begin
                if (en) begin
                    mMode  = 1;
                    mI     = N - 1;
                    mRetry = 0;
                end
            end else if (!en) begin
                mMode = 0;
            end else if (mMode == 2) begin
                if (bus.perm_ready_i) begin
                    for (int k = 0; k < N; k++) mPerm[k] = mWork[k];
                    mValid = 1'b1;
                    mMode  = 1;
                    mI     = N - 1;
                    mRetry = 0;
                end
            end else if (bus.rng_valid_i) begin
                mD = int'(bus.rng_number_i);
                mJ = -1;
                if (mD <= mI) mJ = mD;
                else if (FOLD && (mD - (mI + 1)) <= mI) mJ = mD - (mI + 1);
                else if (mRetry == RL - 1) mJ = mI;
                if (mJ < 0) begin
                    mRetry = mRetry + 1;
                end else begin
                    mTmp      = mWork[mI];
                    mWork[mI] = mWork[mJ];
                    mWork[mJ] = mTmp;
                    mRetry    = 0;
                    if (mI == 1) begin
                        mI = N - 1;
                        if (!mValid) begin
                            for (int k = 0; k < N; k++) mPerm[k] = mWork[k];
                            mValid = 1'b1;
                        end else begin
                            mMode = 2;
                        end
                    end else begin
                        mI = mI - 1;
                    end
                end
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [PW-1:0] expPerm;
        if (cmpOn) begin
            for (int k = 0; k < N; k++) expPerm[k*IW +: IW] = IW'(mPerm[k]);
            checkValue("model_perm", 32'(bus.perm_o), 32'(expPerm));
            checkValue("model_valid", 32'(bus.perm_valid_o), 32'(mValid));
        end
    end

    task automatic applyStimulus(input bit r, input bit e, input logic [IW-1:0] num,
                                 input bit v, input bit rdy, input int cycles);
        rst              = r;
        en               = e;
        bus.rng_number_i = num;
        bus.rng_valid_i  = v;
        bus.perm_ready_i = rdy;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [PW-1:0] expPerm, input bit expValid);
        checkValue({name, "_perm"}, 32'(bus.perm_o), 32'(expPerm));
        checkValue({name, "_valid"}, 32'(bus.perm_valid_o), 32'(expValid));
    endtask

    initial begin
        // Test 1: draws of 0 -> {1,2,3,0}, then {2,3,0,1}
        applyStimulus(1, 0, 0, 0, 0, 2);
        cmpOn = 1'b1;
        checkOutput("reset_state", IDENT, 1'b0);
        applyStimulus(0, 1, 0, 1, 1, 3);
        checkOutput("t1_latency", IDENT, 1'b0);
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("t1_first_perm", 8'h39, 1'b1);
        applyStimulus(0, 1, 0, 1, 1, 3);
        checkOutput("t1_second_perm", 8'h4E, 1'b1);

        // Tests 2/3: draws of 3 -> forced no-swaps, or folding
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("t2_reset", IDENT, 1'b0);
`ifdef SHUFFLEV_PERM_FOLD_EN
        applyStimulus(0, 1, 3, 1, 1, 3);
        checkOutput("t3_pending", IDENT, 1'b0);
        applyStimulus(0, 1, 3, 1, 1, 1);
        checkOutput("t3_fold_perm", 8'hC6, 1'b1);
`else
        applyStimulus(0, 1, 3, 1, 1, 7);
        checkOutput("t2_pending", IDENT, 1'b0);
        applyStimulus(0, 1, 3, 1, 1, 1);
        checkOutput("t2_forced_identity", IDENT, 1'b1);
`endif

        // Test 4: consumer not ready, second perm parks in FULL
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 0, 4);
        checkOutput("t4_first_perm", 8'h39, 1'b1);
        applyStimulus(0, 1, 0, 1, 0, 6);
        checkOutput("t4_held_while_full", 8'h39, 1'b1);
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("t4_second_perm", 8'h4E, 1'b1);
        applyStimulus(0, 1, 0, 1, 0, 5);
        checkOutput("t4_third_pending", 8'h4E, 1'b1);
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("t4_third_perm", 8'h93, 1'b1);

        // Test 5: rng stall adds latency only
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 1, 2);
        applyStimulus(0, 1, 0, 0, 1, 5);
        checkOutput("t5_stalled", IDENT, 1'b0);
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("t5_one_left", IDENT, 1'b0);
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("t5_perm", 8'h39, 1'b1);

        // Test 5b: stall in the middle of a reject run keeps the retry count
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 3, 1, 1, 3);
        applyStimulus(0, 1, 3, 0, 1, 5);
`ifndef SHUFFLEV_PERM_FOLD_EN
        checkOutput("t5b_stalled", IDENT, 1'b0);
`endif
        applyStimulus(0, 1, 3, 1, 1, 4);
`ifndef SHUFFLEV_PERM_FOLD_EN
        checkOutput("t5b_pending", IDENT, 1'b0);
`endif
        applyStimulus(0, 1, 3, 1, 1, 1);
`ifndef SHUFFLEV_PERM_FOLD_EN
        checkOutput("t5b_perm", IDENT, 1'b1);
`endif

        // Test 6: disable mid-shuffle, drain, resume, reset mid-shuffle
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 1, 4);
        checkOutput("t6_perm", 8'h39, 1'b1);
        applyStimulus(0, 1, 0, 1, 0, 2);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("t6_idle_held", 8'h39, 1'b1);
        applyStimulus(0, 0, 0, 1, 0, 3);
        checkOutput("t6_idle_still_held", 8'h39, 1'b1);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("t6_idle_drain", 8'h39, 1'b0);
        applyStimulus(0, 1, 0, 1, 1, 4);
        checkOutput("t6_resume_perm", 8'hD2, 1'b1);
        applyStimulus(0, 1, 0, 1, 1, 2);
        applyStimulus(1, 1, 0, 1, 1, 1);
        checkOutput("t6_mid_reset", IDENT, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 2);
        checkOutput("t6_after_reset", IDENT, 1'b0);

        cmpOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
